// File: rtl/rgmii_tx_framer.sv
// rgmii_tx_framer: byte stream to RGMII SDR nibble frames with preamble/SFD, padding, optional FCS (RGMII_TX_FCS_EN) and IFG
module rgmii_tx_framer #(
    parameter int MIN_FRAME   = 60,
    parameter int IFG_NIBBLES = 24,
    parameter int CNT_W       = 16
) (
    input  logic       rgm0_clk,
    input  logic       rgm0_rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       rgm0_tx_en,
    output logic       rgm0_tx_er,
    output logic [3:0] rgm0_tx_d,
    output logic       busy
);
    localparam int NW = $clog2(IFG_NIBBLES + 16);
    localparam logic [CNT_W:0] MIN_W = (CNT_W + 1)'(MIN_FRAME);

    typedef enum logic [3:0] {IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, ABORT, DRAIN, IFG} state_t;

`ifdef RGMII_TX_FCS_EN
    localparam state_t POST = FCS;
`else
    localparam state_t POST = IFG;
`endif

    state_t           state_q, state_d;
    logic [NW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       data_q, data_d;
    logic             last_q, last_d;
    logic             s_ready_q, s_ready_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_er_q, tx_er_d;
    logic [3:0]       tx_d_q, tx_d_d;
    logic             busy_q, busy_d;
    logic [3:0]       fcs_nib;
    logic             acc, enough;

    assign acc    = s_valid & s_ready_q;
    assign enough = (&count_q) | ({1'b0, count_q} >= MIN_W);

    assign s_ready    = s_ready_q;
    assign rgm0_tx_en = tx_en_q;
    assign rgm0_tx_er = tx_er_q;
    assign rgm0_tx_d  = tx_d_q;
    assign busy       = busy_q;

`ifdef RGMII_TX_FCS_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc4(input logic [31:0] c, input logic [3:0] n);
        logic [31:0] r;
        r = c ^ {28'd0, n};
        for (int i = 0; i < 4; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    // CRC register: runs over payload+pad nibbles as they hit the wire, then shifts out during FCS
    always_ff @(posedge rgm0_clk or negedge rgm0_rst_n) begin
        if (!rgm0_rst_n) crc_q <= '1;
        else             crc_q <= crc_d;
    end

    // Next CRC: fold in the nibble just sent, or shift one nibble per FCS cycle
    always_comb begin
        crc_d = (state_q == PAYLOAD || state_q == PAD) ? crc4(crc_q, tx_d_q) :
                (state_q == FCS) ? {4'hF, crc_q[31:4]} : '1;
    end

    assign fcs_nib = (state_d == FCS) ? ~crc_d[3:0] : 4'h0;
`else
    assign fcs_nib = 4'h0;
`endif

    // State register
    always_ff @(posedge rgm0_clk or negedge rgm0_rst_n) begin
        if (!rgm0_rst_n) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Datapath and registered outputs
    always_ff @(posedge rgm0_clk or negedge rgm0_rst_n) begin
        if (!rgm0_rst_n) begin
            cnt_q     <= '0;
            count_q   <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            s_ready_q <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            tx_d_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            count_q   <= count_d;
            data_q    <= data_d;
            last_q    <= last_d;
            s_ready_q <= s_ready_d;
            tx_en_q   <= tx_en_d;
            tx_er_q   <= tx_er_d;
            tx_d_q    <= tx_d_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state: each state lasts a fixed number of nibbles except PAYLOAD/PAD/DRAIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = s_valid ? PREAMBLE : IDLE;
            PREAMBLE: if (cnt_q == NW'(13)) state_d = SFD;
            SFD:      if (cnt_q[0]) state_d = acc ? PAYLOAD : ABORT;
            PAYLOAD:  if (cnt_q[0]) state_d = last_q ? (enough ? POST : PAD) : (acc ? PAYLOAD : ABORT);
            PAD:      if (cnt_q[0] && enough) state_d = POST;
`ifdef RGMII_TX_FCS_EN
            FCS:      if (cnt_q == NW'(7)) state_d = IFG;
`endif
            ABORT:    if (cnt_q[0]) state_d = DRAIN;
            DRAIN:    if (acc && s_last) state_d = IFG;
            IFG:      if (cnt_q == NW'(IFG_NIBBLES - 1)) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Counters and byte holding register; byte states restart the nibble counter every byte
    always_comb begin
        cnt_d   = (state_d != state_q || ((state_q == PAYLOAD || state_q == PAD) && cnt_q[0])) ? '0 : cnt_q + 1'b1;
        data_d  = acc ? s_data : data_q;
        last_d  = acc ? s_last : last_q;
        count_d = (state_q == IDLE) ? '0 :
                  ((acc && state_q != DRAIN) || (state_d == PAD && cnt_d == '0)) ? ((&count_q) ? count_q : count_q + 1'b1) :
                  count_q;
    end

    // Outputs for the nibble that the next state puts on the wire
    always_comb begin
        tx_en_d   = state_d inside {PREAMBLE, SFD, PAYLOAD, PAD, FCS, ABORT};
        tx_er_d   = state_d == ABORT;
        tx_d_d    = (state_d == PREAMBLE) ? 4'h5 :
                    (state_d == SFD)      ? (cnt_d[0] ? 4'hD : 4'h5) :
                    (state_d == PAYLOAD)  ? (cnt_d[0] ? data_d[7:4] : data_d[3:0]) :
                    (state_d == ABORT)    ? 4'hE : fcs_nib;
        s_ready_d = (state_d == SFD && cnt_d[0]) || (state_d == PAYLOAD && cnt_d[0] && !last_d) || state_d == DRAIN;
        busy_d    = state_d != IDLE;
    end
endmodule

// File: tb/tb_rgmii_tx_framer.sv
// tb_rgmii_tx_framer: randomized frames vs. a frame-level reference model, scoreboard-checked nibble by nibble
module tb_rgmii_tx_framer;
    localparam int MIN = 60;
    localparam int IFG = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready, tx_en, tx_er, busy;
    logic [3:0] tx_d;

    int total_cnt = 0;
    int pass_cnt = 0;

    logic [5:0] exp_q[$];
    int         gap_q[$];
    logic [7:0] frm[$];
    logic       prev_en = 1'b0;
    logic       last_end = 1'b1;
    int         idle = 0;

    rgmii_tx_framer #(.MIN_FRAME(MIN), .IFG_NIBBLES(IFG), .CNT_W(16)) dut (
        .rgm0_clk(clk), .rgm0_rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .rgm0_tx_en(tx_en), .rgm0_tx_er(tx_er), .rgm0_tx_d(tx_d), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Reference model: a frame is preamble+SFD, the data bytes (zero-padded to MIN), then the bytewise CRC-32
    task automatic model_frame(input int ur);
        logic [7:0]  p[$];
        logic [31:0] c;
        logic [5:0]  t;
        int          n;
        for (int i = 0; i < 15; i++) exp_q.push_back(6'h05);
        exp_q.push_back(6'h0D);
        n = (ur > 0) ? ur : frm.size();
        for (int i = 0; i < n; i++) p.push_back(frm[i]);
        if (ur == 0) while (p.size() < MIN) p.push_back(8'h00);
        foreach (p[i]) begin
            exp_q.push_back({2'b00, p[i][3:0]});
            exp_q.push_back({2'b00, p[i][7:4]});
        end
        if (ur > 0) begin
            exp_q.push_back(6'h1E);
            exp_q.push_back(6'h1E);
        end else begin
`ifdef RGMII_TX_FCS_EN
            c = 32'hFFFFFFFF;
            foreach (p[i]) begin
                c = c ^ {24'd0, p[i]};
                for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : (c >> 1);
            end
            c = ~c;
            for (int k = 0; k < 8; k++) exp_q.push_back({2'b00, c[4*k +: 4]});
`else
            c = '0;
`endif
        end
        t = exp_q.pop_back();
        exp_q.push_back(t | 6'h20);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        s_data = d;
        s_last = l;
        s_valid = 1'b1;
        while (!s_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("ready_timeout", 1'b0, n, 400);
        else @(negedge clk);
    endtask

    task automatic send_frame(input int ur, input bit keep, input int gexp);
        gap_q.push_back(gexp);
        model_frame(ur);
        for (int i = 0; i < frm.size(); i++) begin
            if (ur > 0 && i == ur) begin
                s_valid = 1'b0;
                repeat (4) @(negedge clk);
            end
            send_byte(frm[i], i == frm.size() - 1);
        end
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1'b0, n, 3000);
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic mk_rand(input int len);
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic mk_ascii();
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
    endtask

    // Monitor: pops one expected nibble per tx_en cycle, checks frame boundaries and inter-frame gaps
    always @(negedge clk) begin
        logic [5:0] e;
        int g;
        if (rst_n) begin
            if (tx_en) begin
                if (!prev_en) begin
                    g = (gap_q.size() > 0) ? gap_q.pop_front() : 0;
                    if (g > 0) check("gap_exact", idle == g, idle, g);
                    else if (g < 0) check("gap_min", idle >= -g, idle, -g);
                end
                if (exp_q.size() == 0) check("unexpected_nibble", 1'b0, {tx_er, tx_d}, 0);
                else begin
                    e = exp_q.pop_front();
                    check("nibble", {tx_er, tx_d} == e[4:0], {tx_er, tx_d}, e[4:0]);
                    last_end = e[5];
                end
                check("busy_in_frame", busy, busy, 1);
            end else begin
                if (prev_en) check("frame_end", last_end, last_end, 1);
                check("idle_outputs", {tx_er, tx_d} == 5'd0, {tx_er, tx_d}, 0);
                idle = prev_en ? 1 : idle + 1;
            end
            prev_en = tx_en;
        end
    end

    initial begin
        int len, ur;
        repeat (3) @(negedge clk);
        check("rst_tx_en", tx_en == 1'b0, tx_en, 0);
        check("rst_tx_er", tx_er == 1'b0, tx_er, 0);
        check("rst_tx_d", tx_d == 4'h0, tx_d, 0);
        check("rst_s_ready", s_ready == 1'b0, s_ready, 0);
        check("rst_busy", busy == 1'b0, busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        mk_ascii();
        send_frame(0, 1'b0, 0);
        wait_idle();

        frm.delete();
        frm.push_back(8'hAB);
        send_frame(0, 1'b0, -(IFG + 1));
        wait_idle();

        mk_rand(70);
        send_frame(0, 1'b0, -(IFG + 1));
        wait_idle();

        mk_rand(10);
        send_frame(4, 1'b0, -(IFG + 1));
        wait_idle();

        mk_rand(12);
        send_frame(0, 1'b1, -(IFG + 1));
        mk_rand(5);
        send_frame(0, 1'b0, IFG + 1);
        wait_idle();

        mk_rand(20);
        gap_q.push_back(-(IFG + 1));
        model_frame(0);
        for (int i = 0; i < 5; i++) send_byte(frm[i], 1'b0);
        #1;
        check("pre_reset_in_frame", tx_en == 1'b1, tx_en, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_tx_en", tx_en == 1'b0, tx_en, 0);
        check("arst_tx_er", tx_er == 1'b0, tx_er, 0);
        check("arst_s_ready", s_ready == 1'b0, s_ready, 0);
        check("arst_busy", busy == 1'b0, busy, 0);
        exp_q.delete();
        gap_q.delete();
        prev_en = 1'b0;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mk_ascii();
        send_frame(0, 1'b0, 0);
        wait_idle();

        for (int f = 0; f < 10; f++) begin
            len = $urandom_range(1, 90);
            ur = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
            mk_rand(len);
            send_frame(ur, 1'b0, -(IFG + 1));
            wait_idle();
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
